out_argmax: RTL and testbench
=============================

Name: out_argmax

Overview:
- Downstream consumer of the output PISO stage. It takes the serial stream of per-class scores, one WIDTH-bit word per valid cycle.
- Tracks the running maximum and its arrival index, then reports the winning class once NUM_CLASSES scores have been received.
- Final stage of the MNIST classification path; its result feeds the host/readout interface.

Parameters:
- WIDTH, 8, bit width of each class score (matches the PISO word width).
- NUM_CLASSES, 10, scores per frame (one per class).
- IDX_W, 4, width of the class index and sample counter; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- CLKEXT  in  1  system clock, rising edge.
- CLR_ARGMAX  in  1  asynchronous active-high reset.
- START  in  1  begin a new frame; clears counter and ERR_OVR.
- DATA_IN  in  WIDTH  score word, taken from PISO output DATA_OUT.
- VALID_IN  in  1  DATA_IN holds a new score this cycle (driven alongside the PISO shift enable).
- CLASS_OUT  out  IDX_W  index of the winning class.
- MAX_OUT  out  WIDTH  winning score value.
- DONE  out  1  one-cycle pulse: result valid.
- BUSY  out  1  high while collecting.
- ERR_OVR  out  1  sticky flag: VALID_IN seen while not collecting.

Behaviour:
- Reset (async, immediate): state=IDLE; CLASS_OUT=0, MAX_OUT=0, DONE=0, BUSY=0, ERR_OVR=0, counter=0.
- FSM states: IDLE, COLLECT, RESULT. BUSY = (state==COLLECT). DONE = (state==RESULT). All outputs are registered.
- IDLE:
  - START -> COLLECT; counter=0; ERR_OVR=0.
  - VALID_IN without START -> ERR_OVR=1; sample ignored.
- COLLECT, on VALID_IN:
  - Sample index = counter. Arrival order defines the class index: first word = class 0.
  - counter==0: MAX_OUT<=DATA_IN and CLASS_OUT<=0 unconditionally.
  - Otherwise, replace only if DATA_IN > MAX_OUT (strict). Ties keep the earlier, lower index.
  - counter increments by 1 and never wraps. When counter==NUM_CLASSES-1 and VALID_IN is high, the sample is processed and state -> RESULT.
  - VALID_IN low: hold all state. Gaps of any length are allowed.
- RESULT: lasts exactly one cycle.
  - Latency: DONE is high in the cycle after the edge that captured the last sample.
  - Then -> IDLE. CLASS_OUT and MAX_OUT hold until the first sample of the next frame.
- START has priority in every state. It restarts the frame (counter=0, -> COLLECT) and discards any VALID_IN sample in the same cycle.
  - START in COLLECT aborts the frame; no DONE is issued for it.
  - START in RESULT: DONE still pulses for that cycle, and the next state is COLLECT.
- VALID_IN in RESULT: ERR_OVR=1; sample ignored.
- Comparison width is exactly WIDTH bits; no extension or saturation is needed.

Optional Feature:
- Macro: ARGMAX_SIGNED_EN.
- Defined: DATA_IN and MAX_OUT are compared as two's-complement signed values.
- Undefined: comparison is unsigned.
- The macro changes nothing else: state machine, latency and ports are identical in both builds.

Test Plan:
- Unsigned build, scores 3,7,1,9,2,0,5,4,8,6 on consecutive cycles after START -> CLASS_OUT=3, MAX_OUT=9, DONE high for exactly one cycle, one cycle after the 10th sample; BUSY falls with DONE rising.
- Tie handling: scores 1,2,5,0,0,0,0,5,0,0 with random VALID_IN gaps -> CLASS_OUT=2, MAX_OUT=5; DONE timing is relative to the last valid sample.
- Signedness: scores 0x80,0x7F then 8×0x00.
  - Without ARGMAX_SIGNED_EN -> CLASS_OUT=0, MAX_OUT=0x80.
  - With it -> CLASS_OUT=1, MAX_OUT=0x7F.
- Abort: START, 4 scores of 0xFF, START again with VALID_IN high that cycle (sample dropped), then 10 scores 0..9 -> single DONE, CLASS_OUT=9, MAX_OUT=9.
- Error flag: VALID_IN pulse in IDLE -> ERR_OVR=1, CLASS_OUT/MAX_OUT unchanged; next START -> ERR_OVR=0. VALID_IN during the RESULT cycle also sets ERR_OVR.
- Async reset: assert CLR_ARGMAX between clock edges after 5 samples -> all outputs 0 immediately and state IDLE; a full 10-sample frame afterwards produces the correct result.

Source files
------------

// File: rtl/out_argmax.sv
// Streaming argmax over NUM_CLASSES serial scores; reports the winning class index and value.
// Define ARGMAX_SIGNED_EN to compare scores as two's-complement instead of unsigned.
module out_argmax #(
  parameter int WIDTH       = 8,
  parameter int NUM_CLASSES = 10,
  parameter int IDX_W       = 4
) (
  input  logic             CLKEXT,
  input  logic             CLR_ARGMAX,
  input  logic             START,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic             VALID_IN,
  output logic [IDX_W-1:0] CLASS_OUT,
  output logic [WIDTH-1:0] MAX_OUT,
  output logic             DONE,
  output logic             BUSY,
  output logic             ERR_OVR
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_RESULT
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] r_class;
  logic [WIDTH-1:0] r_max;
  logic             r_done;
  logic             r_busy;
  logic             r_err;
  logic             w_gt;

  always_comb begin
`ifdef ARGMAX_SIGNED_EN
    w_gt = $signed(DATA_IN) > $signed(r_max);
`else
    w_gt = DATA_IN > r_max;
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    if (START) begin
      w_state_nxt = S_COLLECT;
    end else begin
      case (r_state)
        S_IDLE:    w_state_nxt = S_IDLE;
        S_COLLECT: if (VALID_IN && (r_cnt == LAST)) w_state_nxt = S_RESULT;
        S_RESULT:  w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // BUSY/DONE are registered from the next state so they align with r_state.
  always_ff @(posedge CLKEXT or posedge CLR_ARGMAX) begin
    if (CLR_ARGMAX) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_class <= '0;
      r_max   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_COLLECT);
      r_done  <= (w_state_nxt == S_RESULT);
      if (START) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (VALID_IN) begin
        if (r_state == S_COLLECT) begin
          if ((r_cnt == '0) || w_gt) begin
            r_max   <= DATA_IN;
            r_class <= r_cnt;
          end
          if (r_cnt != LAST) r_cnt <= r_cnt + IDX_W'(1);
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

  assign CLASS_OUT = r_class;
  assign MAX_OUT   = r_max;
  assign DONE      = r_done;
  assign BUSY      = r_busy;
  assign ERR_OVR   = r_err;

endmodule

// File: tb/tb_out_argmax.sv
// Scoreboard bench for out_argmax: expected winners queued when a frame is driven, popped at DONE.
module tb_out_argmax;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] din = '0;
  logic       vin = 1'b0;
  logic [3:0] cls;
  logic [7:0] mx;
  logic       done, busy, err;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  typedef logic [7:0] frame_t [10];
  typedef struct packed {logic [3:0] c; logic [7:0] m;} exp_t;
  exp_t sb[$];

  out_argmax #(.WIDTH(8), .NUM_CLASSES(10), .IDX_W(4)) dut (
    .CLKEXT(clk), .CLR_ARGMAX(rst), .START(start), .DATA_IN(din), .VALID_IN(vin),
    .CLASS_OUT(cls), .MAX_OUT(mx), .DONE(done), .BUSY(busy), .ERR_OVR(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  function automatic bit gt(input logic [7:0] a, input logic [7:0] b);
`ifdef ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic exp_t model(input frame_t f);
    exp_t e;
    e.c = 4'd0;
    e.m = f[0];
    for (int i = 1; i < 10; i++)
      if (gt(f[i], e.m)) begin
        e.c = 4'(i);
        e.m = f[i];
      end
    return e;
  endfunction

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Drives one frame (START already issued) and checks DONE latency, result and pulse width.
  task automatic run_frame(input string nm, input frame_t f, input bit gaps, input bit vin_in_result);
    exp_t e;
    sb.push_back(model(f));
    for (int i = 0; i < 10; i++) begin
      if (gaps) begin
        int unsigned k = $urandom_range(0, 3);
        vin = 1'b0;
        for (int unsigned j = 0; j < k; j++) begin @(posedge clk); #1; end
      end
      vin = 1'b1;
      din = f[i];
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_during: busy=%b done=%b expected busy=1 done=0", nm, busy, done);
      end
      @(posedge clk); #1;
    end
    vin = vin_in_result;
    din = 8'hAA;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s done_latency: done=%b busy=%b expected done=1 busy=0", nm, done, busy);
    end
    if (done === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (cls !== e.c || mx !== e.m) begin
        errors++;
        $display("FAIL %s result: class=%0d max=%0h expected class=%0d max=%0h", nm, cls, mx, e.c, e.m);
      end
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
    end
    @(posedge clk); #1;
    vin = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err !== vin_in_result) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b err=%b expected done=0 busy=0 err=%b",
               nm, done, busy, err, vin_in_result);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (cls !== 4'd0 || mx !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cls=%0d max=%0h done=%b busy=%b err=%b expected all 0", cls, mx, done, busy, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    frame_t f = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd0, 8'd5, 8'd4, 8'd8, 8'd6};
    do_start();
    run_frame("basic", f, 1'b0, 1'b0);
    checks++;
    if (cls !== 4'd3 || mx !== 8'd9) begin
      errors++;
      $display("FAIL basic_const: class=%0d max=%0d expected class=3 max=9", cls, mx);
    end
  endtask

  task automatic test_tie();
    frame_t f = '{8'd1, 8'd2, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0, 8'd5, 8'd0, 8'd0};
    do_start();
    run_frame("tie", f, 1'b1, 1'b0);
    checks++;
    if (cls !== 4'd2 || mx !== 8'd5) begin
      errors++;
      $display("FAIL tie_const: class=%0d max=%0d expected class=2 max=5", cls, mx);
    end
  endtask

  task automatic test_signed();
    frame_t f = '{8'h80, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [3:0] ec;
    logic [7:0] em;
`ifdef ARGMAX_SIGNED_EN
    ec = 4'd1; em = 8'h7F;
`else
    ec = 4'd0; em = 8'h80;
`endif
    do_start();
    run_frame("signed", f, 1'b0, 1'b0);
    checks++;
    if (cls !== ec || mx !== em) begin
      errors++;
      $display("FAIL signed_const: class=%0d max=%0h expected class=%0d max=%0h", cls, mx, ec, em);
    end
  endtask

  task automatic test_abort();
    frame_t f = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    int d0;
    do_start();
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      vin = 1'b1; din = 8'hFF;
      @(posedge clk); #1;
    end
    start = 1'b1; vin = 1'b1; din = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0; vin = 1'b0;
    run_frame("abort", f, 1'b0, 1'b0);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL abort_done_count: got %0d expected 1", done_cnt - d0);
    end
    checks++;
    if (cls !== 4'd9 || mx !== 8'd9) begin
      errors++;
      $display("FAIL abort_const: class=%0d max=%0d expected class=9 max=9", cls, mx);
    end
  endtask

  task automatic test_error();
    frame_t f = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd15};
    logic [3:0] c0 = cls;
    logic [7:0] m0 = mx;
    vin = 1'b1; din = 8'hEE;
    @(posedge clk); #1;
    vin = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1 || cls !== c0 || mx !== m0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: err=%b cls=%0d max=%0h busy=%b expected err=1 cls=%0d max=%0h busy=0",
               err, cls, mx, busy, c0, m0);
    end
    do_start();
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_clear: err=%b busy=%b expected err=0 busy=1", err, busy);
    end
    @(posedge clk); #1;
    run_frame("err_result", f, 1'b0, 1'b1);
    checks++;
    if (cls !== 4'd8 || mx !== 8'd90) begin
      errors++;
      $display("FAIL err_result_hold: class=%0d max=%0d expected class=8 max=90", cls, mx);
    end
  endtask

  task automatic test_async_reset();
    frame_t f = '{8'd4, 8'd4, 8'd6, 8'd1, 8'd6, 8'd2, 8'd3, 8'd0, 8'd5, 8'd6};
    do_start();
    for (int i = 0; i < 5; i++) begin
      vin = 1'b1; din = 8'(8'd100 + 8'(i));
      @(posedge clk); #1;
    end
    vin = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cls !== 4'd0 || mx !== 8'd0 || done !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: cls=%0d max=%0h done=%b busy=%b err=%b expected all 0", cls, mx, done, busy, err);
    end
    #2 rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
    @(posedge clk); #1;
    do_start();
    run_frame("post_reset", f, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    frame_t f;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 10; i++) f[i] = 8'($urandom_range(0, 255));
      do_start();
      run_frame("random", f, n[0], 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_abort();
    test_error();
    test_async_reset();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete expected finish");
    $fatal(1, "timeout");
  end

endmodule
